// File: rtl/axi_lite_spill_slice_pkg.sv
// Default AXI-Lite channel and request/response types for the spill slice.
package axi_lite_spill_slice_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ProtWidth = 3;
    localparam int unsigned RespWidth = 2;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [ProtWidth-1:0] prot_t;
    typedef logic [RespWidth-1:0] resp_code_t;

    typedef struct packed {
        addr_t addr;
        prot_t prot;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
    } w_chan_t;

    typedef struct packed {
        resp_code_t resp;
    } b_chan_t;

    typedef struct packed {
        addr_t addr;
        prot_t prot;
    } ar_chan_t;

    typedef struct packed {
        data_t      data;
        resp_code_t resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

endpackage

// File: rtl/axi_lite_spill_slice_stage.sv
// Two-entry spill buffer for one valid/ready channel; optional wire-through bypass.
module axi_lite_spill_stage #(
    parameter type T      = logic,
    parameter bit  Bypass = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic a_full_q, a_full_d;
    logic b_full_q, b_full_d;
    logic ready_q, ready_d;
    T     a_data_q, a_data_d;
    T     b_data_q, b_data_d;
    logic push_c, pop_c;

    assign push_c = valid_i && ready_q;
    assign pop_c  = a_full_q && ready_i;

    // Slot A feeds the output, slot B catches the beat accepted while A is stalled.
    always_comb begin
        a_full_d = a_full_q;
        b_full_d = b_full_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        if (pop_c) begin
            if (b_full_q) begin
                // ready is low while B is full, so no push can coincide here
                a_data_d = b_data_q;
                b_full_d = 1'b0;
            end else if (push_c) begin
                a_data_d = data_i;
            end else begin
                a_full_d = 1'b0;
            end
        end else if (push_c) begin
            if (!a_full_q) begin
                a_data_d = data_i;
                a_full_d = 1'b1;
            end else begin
                b_data_d = data_i;
                b_full_d = 1'b1;
            end
        end
        ready_d = !b_full_d;
    end

    // State registers with synchronous reset; ready held low through reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            ready_q  <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            a_full_q <= a_full_d;
            b_full_q <= b_full_d;
            ready_q  <= ready_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

    // Output select: registered slot A, or straight wires when bypassed.
    always_comb begin
        valid_o = a_full_q;
        ready_o = ready_q;
        data_o  = a_data_q;
        if (Bypass) begin
            valid_o = valid_i;
            ready_o = ready_i;
            data_o  = data_i;
        end
    end

endmodule

// File: rtl/axi_lite_spill_slice.sv
// AXI-Lite register slice: one independent spill stage per channel.
module axi_lite_spill_slice #(
    parameter type aw_chan_t = axi_lite_spill_slice_pkg::aw_chan_t,
    parameter type w_chan_t  = axi_lite_spill_slice_pkg::w_chan_t,
    parameter type b_chan_t  = axi_lite_spill_slice_pkg::b_chan_t,
    parameter type ar_chan_t = axi_lite_spill_slice_pkg::ar_chan_t,
    parameter type r_chan_t  = axi_lite_spill_slice_pkg::r_chan_t,
    parameter type req_t     = axi_lite_spill_slice_pkg::req_t,
    parameter type resp_t    = axi_lite_spill_slice_pkg::resp_t,
    parameter bit  BypassAw  = 1'b0,
    parameter bit  BypassW   = 1'b0,
    parameter bit  BypassB   = 1'b0,
    parameter bit  BypassAr  = 1'b0,
    parameter bit  BypassR   = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    aw_chan_t mst_aw;
    w_chan_t  mst_w;
    b_chan_t  slv_b;
    ar_chan_t mst_ar;
    r_chan_t  slv_r;
    logic     mst_aw_valid, slv_aw_ready;
    logic     mst_w_valid, slv_w_ready;
    logic     slv_b_valid, mst_b_ready;
    logic     mst_ar_valid, slv_ar_ready;
    logic     slv_r_valid, mst_r_ready;

    axi_lite_spill_stage #(.T(aw_chan_t), .Bypass(BypassAw)) i_aw (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.aw_valid),
        .ready_o (slv_aw_ready),
        .data_i  (slv_req_i.aw),
        .valid_o (mst_aw_valid),
        .ready_i (mst_resp_i.aw_ready),
        .data_o  (mst_aw)
    );

    axi_lite_spill_stage #(.T(w_chan_t), .Bypass(BypassW)) i_w (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.w_valid),
        .ready_o (slv_w_ready),
        .data_i  (slv_req_i.w),
        .valid_o (mst_w_valid),
        .ready_i (mst_resp_i.w_ready),
        .data_o  (mst_w)
    );

    axi_lite_spill_stage #(.T(b_chan_t), .Bypass(BypassB)) i_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mst_resp_i.b_valid),
        .ready_o (mst_b_ready),
        .data_i  (mst_resp_i.b),
        .valid_o (slv_b_valid),
        .ready_i (slv_req_i.b_ready),
        .data_o  (slv_b)
    );

    axi_lite_spill_stage #(.T(ar_chan_t), .Bypass(BypassAr)) i_ar (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.ar_valid),
        .ready_o (slv_ar_ready),
        .data_i  (slv_req_i.ar),
        .valid_o (mst_ar_valid),
        .ready_i (mst_resp_i.ar_ready),
        .data_o  (mst_ar)
    );

    axi_lite_spill_stage #(.T(r_chan_t), .Bypass(BypassR)) i_r (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mst_resp_i.r_valid),
        .ready_o (mst_r_ready),
        .data_i  (mst_resp_i.r),
        .valid_o (slv_r_valid),
        .ready_i (slv_req_i.r_ready),
        .data_o  (slv_r)
    );

    // Pack the downstream request bundle.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = mst_aw;
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.w        = mst_w;
        mst_req_o.w_valid  = mst_w_valid;
        mst_req_o.b_ready  = mst_b_ready;
        mst_req_o.ar       = mst_ar;
        mst_req_o.ar_valid = mst_ar_valid;
        mst_req_o.r_ready  = mst_r_ready;
    end

    // Pack the upstream response bundle.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = slv_aw_ready;
        slv_resp_o.w_ready  = slv_w_ready;
        slv_resp_o.b        = slv_b;
        slv_resp_o.b_valid  = slv_b_valid;
        slv_resp_o.ar_ready = slv_ar_ready;
        slv_resp_o.r        = slv_r;
        slv_resp_o.r_valid  = slv_r_valid;
    end

endmodule

// File: tb/tb_axi_lite_spill_slice.sv
// Directed and randomized checks of the AXI-Lite spill slice (W channel bypassed).
module tb_axi_lite_spill_slice;
    import axi_lite_spill_slice_pkg::*;

    logic  clk;
    logic  rst;
    req_t  slv_req;
    resp_t slv_resp;
    req_t  mst_req;
    resp_t mst_resp;

    int vectors = 0;
    int errs    = 0;

    axi_lite_spill_slice #(.BypassW(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic rdy);
        chk({tag, "_aw_valid"}, 64'(mst_req.aw_valid), 64'(0));
        chk({tag, "_ar_valid"}, 64'(mst_req.ar_valid), 64'(0));
        chk({tag, "_b_valid"},  64'(slv_resp.b_valid), 64'(0));
        chk({tag, "_r_valid"},  64'(slv_resp.r_valid), 64'(0));
        chk({tag, "_aw_ready"}, 64'(slv_resp.aw_ready), 64'(rdy));
        chk({tag, "_ar_ready"}, 64'(slv_resp.ar_ready), 64'(rdy));
        chk({tag, "_b_ready"},  64'(mst_req.b_ready), 64'(rdy));
        chk({tag, "_r_ready"},  64'(mst_req.r_ready), 64'(rdy));
    endtask

    logic [31:0] aw_q[$];
    logic [31:0] r_q[$];

    initial begin
        logic [31:0] aw_seq, r_seq, aw_prev, r_prev, exp_v;
        logic        aw_hold, r_hold, aw_stall, r_stall;
        logic        aw_push, aw_pop, r_push, r_pop;

        // Reset with every valid and ready asserted
        slv_req  = '0;
        mst_resp = '0;
        rst      = 1'b1;
        slv_req.aw_valid  = 1'b1;
        slv_req.w_valid   = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.b_valid  = 1'b1;
        mst_resp.r_valid  = 1'b1;
        tick();
        chk_regs("rst1", 1'b0);
        tick();
        tick();
        chk_regs("rst3", 1'b0);

        rst = 1'b0;
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        slv_req.ar_valid = 1'b0;
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        tick();
        chk_regs("post_rst", 1'b1);

        // Streaming AW 0x0..0xF, one beat per cycle
        for (int k = 0; k < 16; k++) begin
            slv_req.aw_valid = 1'b1;
            slv_req.aw.addr  = 32'(k);
            chk("stream_aw_ready", 64'(slv_resp.aw_ready), 64'(1));
            tick();
            chk("stream_out_valid", 64'(mst_req.aw_valid), 64'(1));
            chk("stream_out_addr", 64'(mst_req.aw.addr), 64'(k));
        end
        slv_req.aw_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(mst_req.aw_valid), 64'(0));

        // Backpressure: 0x10, 0x14 buffered, 0x18 held upstream
        mst_resp.aw_ready = 1'b0;
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 32'h10;
        chk("bp_c0_ready", 64'(slv_resp.aw_ready), 64'(1));
        tick();
        slv_req.aw.addr = 32'h14;
        chk("bp_c1_ready", 64'(slv_resp.aw_ready), 64'(1));
        chk("bp_c1_addr", 64'(mst_req.aw.addr), 64'h10);
        tick();
        slv_req.aw.addr = 32'h18;
        chk("bp_c2_ready", 64'(slv_resp.aw_ready), 64'(0));
        chk("bp_c2_addr", 64'(mst_req.aw.addr), 64'h10);
        tick();
        chk("bp_c3_ready", 64'(slv_resp.aw_ready), 64'(0));
        chk("bp_c3_valid", 64'(mst_req.aw_valid), 64'(1));
        chk("bp_c3_addr", 64'(mst_req.aw.addr), 64'h10);
        mst_resp.aw_ready = 1'b1;
        tick();
        chk("bp_c4_addr", 64'(mst_req.aw.addr), 64'h14);
        chk("bp_c4_ready", 64'(slv_resp.aw_ready), 64'(1));
        tick();
        chk("bp_c5_addr", 64'(mst_req.aw.addr), 64'h18);
        chk("bp_c5_valid", 64'(mst_req.aw_valid), 64'(1));
        slv_req.aw_valid = 1'b0;
        tick();
        chk("bp_c6_valid", 64'(mst_req.aw_valid), 64'(0));

        // Simultaneous push and pop on R
        slv_req.r_ready   = 1'b0;
        mst_resp.r_valid  = 1'b1;
        mst_resp.r.data   = 32'hAAAA;
        mst_resp.r.resp   = 2'b00;
        tick();
        mst_resp.r.data = 32'hBBBB;
        slv_req.r_ready = 1'b1;
        chk("pp_a_valid", 64'(slv_resp.r_valid), 64'(1));
        chk("pp_a_data", 64'(slv_resp.r.data), 64'hAAAA);
        chk("pp_a_ready", 64'(mst_req.r_ready), 64'(1));
        tick();
        chk("pp_b_data", 64'(slv_resp.r.data), 64'hBBBB);
        chk("pp_b_valid", 64'(slv_resp.r_valid), 64'(1));
        chk("pp_b_ready", 64'(mst_req.r_ready), 64'(1));
        mst_resp.r_valid = 1'b0;
        tick();
        chk("pp_empty", 64'(slv_resp.r_valid), 64'(0));

        // Independence: B stalled while AR and R stream
        slv_req.b_ready   = 1'b0;
        mst_resp.ar_ready = 1'b1;
        slv_req.r_ready   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            slv_req.ar_valid = 1'b1;
            slv_req.ar.addr  = 32'h100 + 32'(k);
            mst_resp.r_valid = 1'b1;
            mst_resp.r.data  = 32'h50 + 32'(k);
            mst_resp.b_valid = (k == 0);
            mst_resp.b.resp  = 2'b10;
            tick();
            chk("ind_ar_valid", 64'(mst_req.ar_valid), 64'(1));
            chk("ind_ar_addr", 64'(mst_req.ar.addr), 64'h100 + 64'(k));
            chk("ind_r_valid", 64'(slv_resp.r_valid), 64'(1));
            chk("ind_r_data", 64'(slv_resp.r.data), 64'h50 + 64'(k));
            chk("ind_b_valid", 64'(slv_resp.b_valid), 64'(1));
            chk("ind_b_resp", 64'(slv_resp.b.resp), 64'(2));
        end
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b1;
        tick();
        chk("ind_b_drained", 64'(slv_resp.b_valid), 64'(0));
        chk("ind_ar_drained", 64'(mst_req.ar_valid), 64'(0));
        chk("ind_r_drained", 64'(slv_resp.r_valid), 64'(0));

        // Bypassed W propagates combinationally; AW keeps its register
        mst_resp.w_ready = 1'b0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 32'hCAFE;
        slv_req.w.strb   = 4'hF;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h77;
        #1;
        chk("byp_w_valid", 64'(mst_req.w_valid), 64'(1));
        chk("byp_w_data", 64'(mst_req.w.data), 64'hCAFE);
        chk("byp_w_ready_lo", 64'(slv_resp.w_ready), 64'(0));
        chk("byp_aw_latency", 64'(mst_req.aw_valid), 64'(0));
        mst_resp.w_ready = 1'b1;
        #1;
        chk("byp_w_ready_hi", 64'(slv_resp.w_ready), 64'(1));
        tick();
        chk("byp_aw_valid", 64'(mst_req.aw_valid), 64'(1));
        chk("byp_aw_addr", 64'(mst_req.aw.addr), 64'h77);
        slv_req.w_valid  = 1'b0;
        slv_req.aw_valid = 1'b0;
        tick();

        // Random valid/ready on AW and R against queue scoreboards, then drain
        aw_seq = 32'h1000; r_seq = 32'h2000;
        aw_hold = 1'b0; r_hold = 1'b0; aw_stall = 1'b0; r_stall = 1'b0;
        aw_prev = '0; r_prev = '0;
        for (int c = 0; c < 2006; c++) begin
            if (c >= 2000) begin
                slv_req.aw_valid  = 1'b0;
                mst_resp.r_valid  = 1'b0;
                mst_resp.aw_ready = 1'b1;
                slv_req.r_ready   = 1'b1;
            end else begin
                if (!aw_hold) begin
                    slv_req.aw_valid = 1'($urandom_range(0, 1));
                    slv_req.aw.addr  = aw_seq;
                end
                if (!r_hold) begin
                    mst_resp.r_valid = 1'($urandom_range(0, 1));
                    mst_resp.r.data  = r_seq;
                end
                mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
                slv_req.r_ready   = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (aw_stall) begin
                chk("rnd_aw_stable_v", 64'(mst_req.aw_valid), 64'(1));
                chk("rnd_aw_stable_a", 64'(mst_req.aw.addr), 64'(aw_prev));
            end
            if (r_stall) begin
                chk("rnd_r_stable_v", 64'(slv_resp.r_valid), 64'(1));
                chk("rnd_r_stable_d", 64'(slv_resp.r.data), 64'(r_prev));
            end
            aw_push = slv_req.aw_valid && slv_resp.aw_ready;
            aw_pop  = mst_req.aw_valid && mst_resp.aw_ready;
            r_push  = mst_resp.r_valid && mst_req.r_ready;
            r_pop   = slv_resp.r_valid && slv_req.r_ready;
            if (aw_pop) begin
                chk("rnd_aw_nonempty", 64'(aw_q.size() != 0), 64'(1));
                if (aw_q.size() != 0) begin
                    exp_v = aw_q.pop_front();
                    chk("rnd_aw_order", 64'(mst_req.aw.addr), 64'(exp_v));
                end
            end
            if (r_pop) begin
                chk("rnd_r_nonempty", 64'(r_q.size() != 0), 64'(1));
                if (r_q.size() != 0) begin
                    exp_v = r_q.pop_front();
                    chk("rnd_r_order", 64'(slv_resp.r.data), 64'(exp_v));
                end
            end
            if (aw_push) begin
                aw_q.push_back(slv_req.aw.addr);
                aw_seq = aw_seq + 32'd1;
            end
            if (r_push) begin
                r_q.push_back(mst_resp.r.data);
                r_seq = r_seq + 32'd1;
            end
            aw_hold  = slv_req.aw_valid && !aw_push;
            r_hold   = mst_resp.r_valid && !r_push;
            aw_stall = mst_req.aw_valid && !mst_resp.aw_ready;
            r_stall  = slv_resp.r_valid && !slv_req.r_ready;
            aw_prev  = mst_req.aw.addr;
            r_prev   = slv_resp.r.data;
            tick();
        end
        chk("rnd_aw_lost", 64'(aw_q.size()), 64'(0));
        chk("rnd_r_lost", 64'(r_q.size()), 64'(0));
        chk("rnd_aw_idle", 64'(mst_req.aw_valid), 64'(0));
        chk("rnd_r_idle", 64'(slv_resp.r_valid), 64'(0));
        chk("rnd_aw_seen", 64'(aw_seq > 32'h1100), 64'(1));
        chk("rnd_r_seen", 64'(r_seq > 32'h2100), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
